tone_synth: RTL and testbench

- Audio back end that consumes the per-beat tone frequency (Hz) from the melody lookup stage.
- Synthesises a square wave at that frequency and converts it to signed 16-bit samples.
- Serialises the samples to the board's PMOD I2S DAC as audio_mclk, audio_lrck, audio_sck and audio_sdin.
- Last stage before the speaker pins.

---
 rtl/audio_pkg.sv | 11 +
 rtl/tone_synth_if.sv | 12 +
 rtl/i2s_serializer.sv | 50 +++++
 rtl/tone_synth.sv | 91 +++++++++
 tb/tb_tone_synth.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the tone synthesiser audio path.
package audio_pkg;

   localparam int unsigned SILENCE_THRESH = 20000;
   localparam int          SAMPLE_W       = 16;
   localparam logic [SAMPLE_W-1:0] DEFAULT_AMP = 16'h2000;
   localparam int          FRAME_CNT_W    = 9;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/tone_synth_if.sv
// DAC pin bundle: the serializer drives it, consumers observe it.
interface tone_synth_if;

   logic mclk;
   logic lrck;
   logic sck;
   logic sdin;

   modport master (output mclk, lrck, sck, sdin);
   modport slave  (input  mclk, lrck, sck, sdin);

endinterface

// File: rtl/i2s_serializer.sv
// Left-justified I2S serializer: free-running 9-bit frame counter,
// derived mclk/sck/lrck, and a sample latch refreshed once per frame.
module i2s_serializer
   import audio_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  sample_t      target,
   tone_synth_if.master pins
);

   logic [FRAME_CNT_W-1:0] cnt;
   logic [FRAME_CNT_W-1:0] cnt_nxt;
   sample_t                sample_q;
   sample_t                sample_nxt;
   logic [3:0]             bit_idx;

   // Next counter value, next latched sample and the bit it selects.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      cnt_nxt    = cnt + 1'b1;
      sample_nxt = sample_q;
      if (cnt == '1) begin
         sample_nxt = target;
      end
      bit_idx = 4'd15 - cnt_nxt[7:4];
   end

   // Counter, sample latch and pins; outputs are computed from the next
   // count so clocks and data leave the flops already aligned.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         cnt       <= '0;
         sample_q  <= '0;
         pins.mclk <= 1'b0;
         pins.sck  <= 1'b0;
         pins.lrck <= 1'b0;
         pins.sdin <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         sample_q  <= sample_nxt;
         pins.mclk <= cnt_nxt[1];
         pins.sck  <= cnt_nxt[3];
         pins.lrck <= cnt_nxt[8];
         pins.sdin <= sample_nxt[bit_idx];
      end
   end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesiser feeding a PMOD I2S DAC.
// Optional build macro: TONE_SYNTH_VOLUME_EN (vol scales the amplitude).
module tone_synth #(
   parameter int unsigned CLK_FREQ       = 100_000_000,
   parameter int unsigned SILENCE_THRESH = audio_pkg::SILENCE_THRESH,
   parameter int          ACC_W          = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tone,
   input  logic [2:0]  vol,
   output logic        wave,
   output logic        audio_mclk,
   output logic        audio_lrck,
   output logic        audio_sck,
   output logic        audio_sdin
);

   import audio_pkg::*;

   localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_FREQ);

   logic [31:0]         tone_q;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    step;
   logic [ACC_W-1:0]    sum;
   logic                silent;
   logic                pending;
   logic [SAMPLE_W-1:0] amp;
   sample_t             target;

   // Silence gates the accumulator, so the truncated step never overflows.
   assign silent  = (tone_q == 32'd0) || (tone_q >= SILENCE_THRESH);
   assign pending = (tone_q != tone);
   assign step    = ACC_W'({tone_q, 1'b0});
   assign sum     = acc + step;

   // Input capture and phase accumulator; wave toggles at 2*tone on average.
   always_ff @(posedge clk) begin
      // NOTE: every register, including the accumulator, is cleared by reset so a restart is deterministic.
      if (rst) begin
         tone_q <= '0;
         acc    <= '0;
         wave   <= 1'b0;
      end else begin
         tone_q <= tone;
         if (silent) begin
            acc  <= '0;
            wave <= 1'b0;
         end else if (pending) begin
            acc  <= '0;
         end else if (sum >= MODULUS) begin
            acc  <= sum - MODULUS;
            wave <= ~wave;
         end else begin
            acc  <= sum;
         end
      end
   end

`ifdef TONE_SYNTH_VOLUME_EN
   assign amp = {1'b0, vol, 12'h000};
`else
   logic unused_vol;
   assign amp        = DEFAULT_AMP;
   assign unused_vol = ^vol;
`endif

   // Signed sample the serializer latches at the frame boundary.
   always_comb begin
      target = '0;
      if (!silent) begin
         target = wave ? sample_t'(amp) : -sample_t'(amp);
      end
   end

   tone_synth_if pins ();

   i2s_serializer u_ser (
      .clk    (clk),
      .rst    (rst),
      .target (target),
      .pins   (pins.master)
   );

   assign audio_mclk = pins.mclk;
   assign audio_lrck = pins.lrck;
   assign audio_sck  = pins.sck;
   assign audio_sdin = pins.sdin;

endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth: a closed-form behavioural model pushes
// expected pin states and decoded channel words; a monitor pops and compares.
module tb_tone_synth;

   import audio_pkg::*;

   localparam longint CLK_HZ = 100_000_000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tone = '0;
   logic [2:0]  vol = '0;
   logic        wave;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_sck;
   logic        audio_sdin;

   always #5 clk = ~clk;

   tone_synth dut (
      .clk        (clk),
      .rst        (rst),
      .tone       (tone),
      .vol        (vol),
      .wave       (wave),
      .audio_mclk (audio_mclk),
      .audio_lrck (audio_lrck),
      .audio_sck  (audio_sck),
      .audio_sdin (audio_sdin)
   );

   tone_synth_if mon ();
   assign mon.mclk = audio_mclk;
   assign mon.lrck = audio_lrck;
   assign mon.sck  = audio_sck;
   assign mon.sdin = audio_sdin;

   typedef struct packed {
      logic wave;
      logic mclk;
      logic lrck;
      logic sck;
      logic sdin;
   } pins_t;

   pins_t       pin_q[$];
   logic [15:0] word_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_cnt = 0;
   longint      m_n = 0;
   logic        m_wave = 1'b0;
   logic        m_base = 1'b0;
   logic [31:0] m_tq = '0;
   logic [15:0] m_sample = '0;

   function automatic logic m_silent(input logic [31:0] t);
      return (t == 32'd0) || (t >= SILENCE_THRESH);
   endfunction

   function automatic logic [15:0] m_target(input logic [31:0] t, input logic w, input logic [2:0] v);
      int a;
`ifdef TONE_SYNTH_VOLUME_EN
      a = int'(v) * 4096;
`else
      a = 32'h2000 + 0 * int'(v);
`endif
      if (m_silent(t)) return 16'h0000;
      return w ? 16'(a) : 16'(-a);
   endfunction

   // Wave is derived from the number of steps since the last restart:
   // after n steps it has toggled floor(n*2*tone/CLK_HZ) times.
   initial forever begin
      longint toggles;
      int     k;
      @(posedge clk);
      if (rst) begin
         m_cnt    = 0;
         m_n      = 0;
         m_wave   = 1'b0;
         m_base   = 1'b0;
         m_tq     = '0;
         m_sample = '0;
         word_q.delete();
      end else begin
         if (m_cnt == 511) m_sample = m_target(m_tq, m_wave, vol);
         m_cnt = (m_cnt + 1) % 512;
         if (m_silent(m_tq)) begin
            m_n    = 0;
            m_wave = 1'b0;
            m_base = 1'b0;
         end else if (m_tq != tone) begin
            m_n    = 0;
            m_base = m_wave;
         end else begin
            m_n++;
            toggles = (m_n * 2 * longint'(m_tq)) / CLK_HZ;
            m_wave  = m_base ^ toggles[0];
         end
         m_tq = tone;
      end
      if (m_cnt % 256 == 0) word_q.push_back(m_sample);
      k = (m_cnt >> 4) & 15;
      pin_q.push_back('{wave: m_wave, mclk: m_cnt[1], lrck: m_cnt[8],
                        sck: m_cnt[3], sdin: m_sample[15-k]});
   end

   // ---------------- monitor ----------------
   initial begin
      int          bitcnt = 0;
      logic        prev_sck = 1'b0;
      logic [15:0] word = '0;
      pins_t       e;
      pins_t       a;
      logic [15:0] ew;
      forever begin
         @(posedge clk);
         #1;
         if (pin_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pin_queue: actual=empty required=entry");
         end else begin
            e = pin_q.pop_front();
            a = '{wave: wave, mclk: mon.mclk, lrck: mon.lrck, sck: mon.sck, sdin: mon.sdin};
            check("pins{wave,mclk,lrck,sck,sdin}", 32'(a), 32'(e));
         end
         if (rst) begin
            bitcnt   = 0;
            prev_sck = 1'b0;
         end else begin
            if (mon.sck && !prev_sck) begin
               word = {word[14:0], mon.sdin};
               bitcnt++;
               if (bitcnt == 16) begin
                  bitcnt = 0;
                  if (word_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL word_queue: actual=empty required=entry");
                  end else begin
                     ew = word_q.pop_front();
                     check(mon.lrck ? "right_word" : "left_word", 32'(word), 32'(ew));
                  end
               end
            end
            prev_sck = mon.sck;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run(input logic [31:0] t, input int cycles);
      tone = t;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic wait_cnt(input int target_cnt);
      for (int i = 0; i < 1024 && m_cnt != target_cnt; i++) @(negedge clk);
   endtask

   initial begin
      logic [31:0] t;
      rst  = 1'b1;
      tone = '0;
      vol  = 3'(($urandom % 7) + 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run(32'd4000, 26000);          // both wave levels, several frames each
      run(32'd20000, 2048);          // threshold is silent
      run(32'd0, 2048);              // zero is silent
      run(32'd19999, 2000);          // one below threshold is audible
      run(32'hFFFF_FFFF, 1000);      // all-ones is silent

      run(32'd6600, 3000);           // mid-frame frequency switch
      wait_cnt(128);
      run(32'd4940, 6000);

      tone = 32'd3000;               // reset in the middle of a frame
      wait_cnt(300);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run(32'd3000, 1500);

      for (int v = 0; v < 8; v++) begin
         vol = 3'(v);
         run(32'd6000, 1024);
      end

      for (int s = 0; s < 14; s++) begin
         case ($urandom % 5)
            0:       t = 32'd0;
            1:       t = SILENCE_THRESH + ($urandom % 1000);
            default: t = $urandom_range(1, SILENCE_THRESH - 1);
         endcase
         vol = 3'($urandom);
         run(t, $urandom_range(400, 2500));
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
